// File: rtl/avs_ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings plus the Avalon-to-AHB bridge state and response codes.
package avs_ahb_lite_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_1 = 3'b000;
    localparam logic [2:0] HSIZE_2 = 3'b001;
    localparam logic [2:0] HSIZE_4 = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    localparam logic [1:0] AVS_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AVS_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ACK
    } state_t;

endpackage

// File: rtl/avs_ahb_lite_master_if.sv
// AHB-Lite bus bundle; master drives address/control/write data, slave returns data and status.
interface avs_ahb_lite_master_if #(
    parameter int HADDR_WIDTH = 32,
    parameter int HDATA_WIDTH = 32
);
    logic [HADDR_WIDTH-1:0] HADDR;
    logic [2:0]             HBURST;
    logic                   HMASTLOCK;
    logic [3:0]             HPROT;
    logic [2:0]             HSIZE;
    logic [1:0]             HTRANS;
    logic                   HWRITE;
    logic [HDATA_WIDTH-1:0] HWDATA;
    logic [HDATA_WIDTH-1:0] HRDATA;
    logic                   HREADY;
    logic                   HRESP;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/avs_ahb_lite_master_be_decode.sv
// Maps an Avalon byteenable to AHB transfer size and byte offset; odd patterns fall back to a word.
module avs_be_decode
    import avs_ahb_lite_master_pkg::*;
(
    input  logic [3:0] byteenable,
    output logic [2:0] hsize,
    output logic [1:0] offset,
    output logic       unsupported
);

    always_comb begin
        hsize       = HSIZE_4;
        offset      = 2'd0;
        unsupported = 1'b0;
        case (byteenable)
            4'b0001: begin hsize = HSIZE_1; offset = 2'd0; end
            4'b0010: begin hsize = HSIZE_1; offset = 2'd1; end
            4'b0100: begin hsize = HSIZE_1; offset = 2'd2; end
            4'b1000: begin hsize = HSIZE_1; offset = 2'd3; end
            4'b0011: begin hsize = HSIZE_2; offset = 2'd0; end
            4'b1100: begin hsize = HSIZE_2; offset = 2'd2; end
            4'b1111: begin hsize = HSIZE_4; offset = 2'd0; end
            default: unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/avs_ahb_lite_master.sv
// Avalon-MM slave to AHB-Lite master bridge: single-beat, one outstanding transfer, non-pipelined.
module avs_ahb_lite_master
    import avs_ahb_lite_master_pkg::*;
#(
    parameter int                     AADDR_WIDTH = 27,
    parameter int                     HADDR_WIDTH = 32,
    parameter int                     HDATA_WIDTH = 32,
    parameter logic [HADDR_WIDTH-1:0] HADDR_BASE  = '0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [AADDR_WIDTH-1:0] avs_address,
    input  logic [3:0]             avs_byteenable,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [HDATA_WIDTH-1:0] avs_writedata,
    output logic                   avs_waitrequest,
    output logic [HDATA_WIDTH-1:0] avs_readdata,
    output logic                   avs_readdatavalid,
    output logic [1:0]             avs_response,
    output logic                   err_sticky,
    avs_ahb_lite_master_if.master  ahb
);

    state_t                 state_reg;
    logic [HADDR_WIDTH-1:0] haddr_reg;
    logic [2:0]             hsize_reg;
    logic [1:0]             htrans_reg;
    logic                   hwrite_reg;
    logic [HDATA_WIDTH-1:0] hwdata_reg;
    logic [HDATA_WIDTH-1:0] wdata_reg;
    logic                   waitrequest_reg;
    logic                   readdatavalid_reg;
    logic [HDATA_WIDTH-1:0] readdata_reg;
    logic [1:0]             response_reg;
    logic                   err_sticky_reg;
    logic                   xfer_err_reg;

    logic [2:0]             be_hsize;
    logic [1:0]             be_offset;
    logic                   be_unsupported;
    logic [HADDR_WIDTH-1:0] byte_addr;
    logic [HADDR_WIDTH-1:0] haddr_next;

    avs_be_decode u_be_decode (
        .byteenable  (avs_byteenable),
        .hsize       (be_hsize),
        .offset      (be_offset),
        .unsupported (be_unsupported)
    );

    // Word address is zero-extended to a byte address; the base add wraps naturally.
    always_comb begin
        byte_addr                    = '0;
        byte_addr[AADDR_WIDTH+1:0]   = {avs_address, be_offset};
        haddr_next                   = HADDR_BASE + byte_addr;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg         <= S_IDLE;
            haddr_reg         <= '0;
            hsize_reg         <= '0;
            htrans_reg        <= HTRANS_IDLE;
            hwrite_reg        <= 1'b0;
            hwdata_reg        <= '0;
            wdata_reg         <= '0;
            waitrequest_reg   <= 1'b1;
            readdatavalid_reg <= 1'b0;
            readdata_reg      <= '0;
            response_reg      <= AVS_RESP_OKAY;
            err_sticky_reg    <= 1'b0;
            xfer_err_reg      <= 1'b0;
        end else begin
            readdatavalid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (avs_read || avs_write) begin
                        state_reg  <= S_ADDR;
                        htrans_reg <= HTRANS_NONSEQ;
                        haddr_reg  <= haddr_next;
                        hsize_reg  <= be_hsize;
                        hwrite_reg <= avs_write;
                        wdata_reg  <= avs_writedata;
                        // Simultaneous read+write resolves as a write but is still flagged.
                        if ((avs_read && avs_write) || be_unsupported)
                            err_sticky_reg <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (ahb.HREADY) begin
                        state_reg  <= S_DATA;
                        htrans_reg <= HTRANS_IDLE;
                        hwdata_reg <= wdata_reg;
                    end
                end
                S_DATA: begin
                    if (ahb.HREADY) begin
                        state_reg       <= S_ACK;
                        waitrequest_reg <= 1'b0;
                        xfer_err_reg    <= ahb.HRESP;
                        if (!hwrite_reg)
                            readdata_reg <= ahb.HRDATA;
                        if (ahb.HRESP)
                            err_sticky_reg <= 1'b1;
                    end
                end
                S_ACK: begin
                    state_reg       <= S_IDLE;
                    waitrequest_reg <= 1'b1;
                    if (!hwrite_reg) begin
                        readdatavalid_reg <= 1'b1;
                        response_reg      <= xfer_err_reg ? AVS_RESP_SLVERR : AVS_RESP_OKAY;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign avs_waitrequest   = waitrequest_reg;
    assign avs_readdata      = readdata_reg;
    assign avs_readdatavalid = readdatavalid_reg;
    assign avs_response      = response_reg;
    assign err_sticky        = err_sticky_reg;

    assign ahb.HADDR     = haddr_reg;
    assign ahb.HBURST    = HBURST_SINGLE;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HPROT     = HPROT_DATA_PRIV;
    assign ahb.HSIZE     = hsize_reg;
    assign ahb.HTRANS    = htrans_reg;
    assign ahb.HWRITE    = hwrite_reg;
    assign ahb.HWDATA    = hwdata_reg;

endmodule

// File: tb/tb_avs_ahb_lite_master.sv
// Directed bench for the Avalon-to-AHB-Lite bridge with hand-computed expectations.
module tb_avs_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [26:0] avs_address;
    logic [3:0]  avs_byteenable;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [1:0]  avs_response;
    logic        err_sticky;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    avs_ahb_lite_master_if #(.HADDR_WIDTH(32), .HDATA_WIDTH(32)) ahb ();

    avs_ahb_lite_master dut (
        .HCLK              (HCLK),
        .HRESET            (HRESET),
        .avs_address       (avs_address),
        .avs_byteenable    (avs_byteenable),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_response      (avs_response),
        .err_sticky        (err_sticky),
        .ahb               (ahb)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESET         = 1'b1;
        avs_address    = '0;
        avs_byteenable = 4'b0000;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        ahb.HRDATA     = '0;
        ahb.HREADY     = 1'b1;
        ahb.HRESP      = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_htrans", 32'(ahb.HTRANS), 32'h0);
        chk("rst_haddr", ahb.HADDR, 32'h0);
        chk("rst_hwrite", 32'(ahb.HWRITE), 32'h0);
        chk("rst_hsize", 32'(ahb.HSIZE), 32'h0);
        chk("rst_hwdata", ahb.HWDATA, 32'h0);
        chk("rst_waitreq", 32'(avs_waitrequest), 32'h1);
        chk("rst_rdv", 32'(avs_readdatavalid), 32'h0);
        chk("rst_resp", 32'(avs_response), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_err", 32'(err_sticky), 32'h0);
        chk("const_hburst", 32'(ahb.HBURST), 32'h0);
        chk("const_hprot", 32'(ahb.HPROT), 32'h3);
        chk("const_hlock", 32'(ahb.HMASTLOCK), 32'h0);
        HRESET = 1'b0;
        tick();
        $display("txn reset: done");

        // Zero-wait word read
        avs_address = 27'h100; avs_byteenable = 4'b1111; avs_read = 1'b1;
        ahb.HRDATA = 32'hDEADBEEF;
        tick();
        chk("rd_c1_htrans", 32'(ahb.HTRANS), 32'h2);
        chk("rd_c1_haddr", ahb.HADDR, 32'h400);
        chk("rd_c1_hsize", 32'(ahb.HSIZE), 32'h2);
        chk("rd_c1_hwrite", 32'(ahb.HWRITE), 32'h0);
        chk("rd_c1_waitreq", 32'(avs_waitrequest), 32'h1);
        tick();
        chk("rd_c2_htrans", 32'(ahb.HTRANS), 32'h0);
        chk("rd_c2_waitreq", 32'(avs_waitrequest), 32'h1);
        tick();
        chk("rd_c3_waitreq", 32'(avs_waitrequest), 32'h0);
        chk("rd_c3_rdv", 32'(avs_readdatavalid), 32'h0);
        avs_read = 1'b0;
        tick();
        chk("rd_c4_rdv", 32'(avs_readdatavalid), 32'h1);
        chk("rd_c4_rdata", avs_readdata, 32'hDEADBEEF);
        chk("rd_c4_resp", 32'(avs_response), 32'h0);
        chk("rd_c4_waitreq", 32'(avs_waitrequest), 32'h1);
        $display("txn read addr=0x100 be=1111 rdata=0x%08h", avs_readdata);

        // Byte write, issued during the readdatavalid cycle
        avs_address = 27'h10; avs_byteenable = 4'b0100; avs_write = 1'b1;
        avs_writedata = 32'h00AB0000;
        tick();
        chk("wr_c1_htrans", 32'(ahb.HTRANS), 32'h2);
        chk("wr_c1_haddr", ahb.HADDR, 32'h42);
        chk("wr_c1_hsize", 32'(ahb.HSIZE), 32'h0);
        chk("wr_c1_hwrite", 32'(ahb.HWRITE), 32'h1);
        chk("wr_c1_rdv", 32'(avs_readdatavalid), 32'h0);
        tick();
        chk("wr_c2_htrans", 32'(ahb.HTRANS), 32'h0);
        chk("wr_c2_hwdata", ahb.HWDATA, 32'h00AB0000);
        tick();
        chk("wr_c3_waitreq", 32'(avs_waitrequest), 32'h0);
        avs_write = 1'b0;
        tick();
        chk("wr_c4_rdv", 32'(avs_readdatavalid), 32'h0);
        chk("wr_c4_waitreq", 32'(avs_waitrequest), 32'h1);
        chk("wr_err", 32'(err_sticky), 32'h0);
        $display("txn write addr=0x10 be=0100 haddr=0x42");

        // Halfword read with 3 address-phase and 2 data-phase wait states
        avs_address = 27'h3; avs_byteenable = 4'b0011; avs_read = 1'b1;
        ahb.HRDATA = 32'h1234ABCD; ahb.HREADY = 1'b0;
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk("ws_addr_htrans", 32'(ahb.HTRANS), 32'h2);
            chk("ws_addr_haddr", ahb.HADDR, 32'hC);
            chk("ws_addr_hsize", 32'(ahb.HSIZE), 32'h1);
            if (c == 4) ahb.HREADY = 1'b1;
            tick();
        end
        ahb.HREADY = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            chk("ws_data_htrans", 32'(ahb.HTRANS), 32'h0);
            chk("ws_data_waitreq", 32'(avs_waitrequest), 32'h1);
            if (c == 7) ahb.HREADY = 1'b1;
            tick();
        end
        chk("ws_c8_waitreq", 32'(avs_waitrequest), 32'h0);
        avs_read = 1'b0;
        tick();
        chk("ws_c9_rdv", 32'(avs_readdatavalid), 32'h1);
        chk("ws_c9_rdata", avs_readdata, 32'h1234ABCD);
        $display("txn read-waits addr=0x3 be=0011 rdata=0x%08h", avs_readdata);

        // Unsupported byteenable on write
        avs_address = 27'h5; avs_byteenable = 4'b0101; avs_write = 1'b1;
        avs_writedata = 32'h11223344;
        tick();
        chk("ube_haddr", ahb.HADDR, 32'h14);
        chk("ube_hsize", 32'(ahb.HSIZE), 32'h2);
        chk("ube_hwrite", 32'(ahb.HWRITE), 32'h1);
        chk("ube_err", 32'(err_sticky), 32'h1);
        tick();
        chk("ube_hwdata", ahb.HWDATA, 32'h11223344);
        tick();
        chk("ube_waitreq", 32'(avs_waitrequest), 32'h0);
        avs_write = 1'b0;
        tick();
        $display("txn write be=0101 haddr=0x%08h err_sticky=%0b", ahb.HADDR, err_sticky);

        // Reset while stalled in the data phase
        avs_address = 27'h40; avs_byteenable = 4'b1111; avs_read = 1'b1;
        ahb.HRDATA = 32'hCAFEF00D;
        tick();
        chk("rst_mid_c1_htrans", 32'(ahb.HTRANS), 32'h2);
        tick();
        ahb.HREADY = 1'b0; HRESET = 1'b1; avs_read = 1'b0;
        tick();
        HRESET = 1'b0; ahb.HREADY = 1'b1;
        chk("rst_mid_htrans", 32'(ahb.HTRANS), 32'h0);
        chk("rst_mid_waitreq", 32'(avs_waitrequest), 32'h1);
        chk("rst_mid_rdv", 32'(avs_readdatavalid), 32'h0);
        chk("rst_mid_err", 32'(err_sticky), 32'h0);
        chk("rst_mid_haddr", ahb.HADDR, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_mid_quiet_rdv", 32'(avs_readdatavalid), 32'h0);
            chk("rst_mid_quiet_waitreq", 32'(avs_waitrequest), 32'h1);
        end
        $display("txn reset-in-data: abandoned");

        avs_read = 1'b1;
        tick();
        chk("post_rst_haddr", ahb.HADDR, 32'h100);
        chk("post_rst_htrans", 32'(ahb.HTRANS), 32'h2);
        tick();
        tick();
        chk("post_rst_waitreq", 32'(avs_waitrequest), 32'h0);
        avs_read = 1'b0;
        tick();
        chk("post_rst_rdv", 32'(avs_readdatavalid), 32'h1);
        chk("post_rst_rdata", avs_readdata, 32'hCAFEF00D);
        chk("post_rst_resp", 32'(avs_response), 32'h0);
        $display("txn read addr=0x40 rdata=0x%08h", avs_readdata);

        // AHB error response on a byte read
        avs_address = 27'h20; avs_byteenable = 4'b1000; avs_read = 1'b1;
        ahb.HRDATA = 32'hBAD0BAD0;
        tick();
        chk("err_haddr", ahb.HADDR, 32'h83);
        chk("err_hsize", 32'(ahb.HSIZE), 32'h0);
        tick();
        ahb.HRESP = 1'b1; ahb.HREADY = 1'b0;
        tick();
        chk("err_first_waitreq", 32'(avs_waitrequest), 32'h1);
        chk("err_first_htrans", 32'(ahb.HTRANS), 32'h0);
        chk("err_first_sticky", 32'(err_sticky), 32'h0);
        ahb.HREADY = 1'b1;
        tick();
        chk("err_ack_waitreq", 32'(avs_waitrequest), 32'h0);
        chk("err_ack_sticky", 32'(err_sticky), 32'h1);
        avs_read = 1'b0; ahb.HRESP = 1'b0;
        tick();
        chk("err_rdv", 32'(avs_readdatavalid), 32'h1);
        chk("err_resp", 32'(avs_response), 32'h2);
        chk("err_rdata", avs_readdata, 32'hBAD0BAD0);
        tick();
        chk("err_rdv_once", 32'(avs_readdatavalid), 32'h0);
        chk("err_sticky_hold", 32'(err_sticky), 32'h1);
        $display("txn read-error addr=0x20 resp=%0b rdata=0x%08h", avs_response, avs_readdata);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
